dispatch_team_allocator: RTL
============================

Name: dispatch_team_allocator

Overview:
- Sits directly downstream of the request-queue top level (Evac/Shelter/Food queues plus final selector).
- Owns a pool of NUM_TEAMS rescue teams and pulls requests from the queue head when a team is free.
- For each request: issues a one-cycle Serve, captures the head Zone/Priority, binds it to the lowest-index free team, and runs a priority-scaled mission timer.
- Releases the team when its timer expires.

Parameters:
NUM_TEAMS, 4, number of rescue teams (2..8)
TEAM_W, 2, width of team index; must equal clog2(NUM_TEAMS)
MISSION_BASE, 8, mission cycles for Priority 0
MISSION_STEP, 4, extra mission cycles per Priority unit
TIMER_W, 8, mission timer width

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Enable  in  1  allows new dispatches; has no effect on running timers
Recall  in  1  synchronous abort: frees all teams, cancels pending issue
Evac_Empty  in  1  evac queue empty flag
Shelter_Valid  in  1  shelter queue head valid
Food_Valid  in  1  food queue head valid
Head_Zone  in  8  queue output zone (combinational, current head)
Head_Priority  in  2  queue output priority
Serve  out  1  one-cycle pop strobe to queue top
Dispatch_Valid  out  1  one-cycle pulse: a dispatch was captured
Dispatch_Team  out  TEAM_W  team index of last dispatch
Dispatch_Zone  out  8  zone of last dispatch
Dispatch_Priority  out  2  priority of last dispatch
Team_Busy  out  NUM_TEAMS  per-team busy flags
Team_Done  out  NUM_TEAMS  per-team one-cycle completion pulses
Dispatch_Count  out  16  total dispatches, saturating

Behaviour:
- Signal definitions:
  - avail = ~Evac_Empty | Shelter_Valid | Food_Valid
  - free = ~Team_Busy (registered vector)
  - any_free = |free
- Reset (async, active-high): FSM = IDLE; all outputs 0; all timers 0; Dispatch_Count = 0.
- FSM states: IDLE, ISSUE, SETTLE.
  - IDLE -> ISSUE when Enable & avail & any_free & ~Recall; otherwise stay in IDLE.
  - ISSUE:
    - Serve = avail & any_free & ~Recall (combinational on state). If Serve = 0, abort to IDLE with no capture.
    - If Serve = 1, in the same cycle: sel = lowest-index set bit of free; latch Head_Zone/Head_Priority into Dispatch_Zone/Dispatch_Priority; Dispatch_Team = sel.
    - Registered effects next edge: Team_Busy[sel] = 1; timer[sel] = MISSION_BASE + MISSION_STEP*Head_Priority, computed in TIMER_W bits with no overflow at defaults; Dispatch_Valid pulses for one cycle.
    - Then go to SETTLE.
  - SETTLE: one dead cycle so the queue head reflects the pop; then unconditionally to IDLE.
- Latency and throughput:
  - Condition true in cycle N (IDLE) -> Serve high in N+1 -> Dispatch_Valid and Team_Busy high in N+2.
  - Maximum throughput: one dispatch per 3 cycles.
- Timers:
  - Each busy team decrements its timer by 1 per cycle.
  - When a timer is 1 at an edge, it goes to 0, Team_Busy[i] clears, and Team_Done[i] pulses for one cycle.
  - A team cleared at edge E is eligible only from the cycle after E. There is no same-edge reuse.
- Dispatch_Count: increments on each Serve; holds at 16'hFFFF.
- Recall:
  - Next edge: Team_Busy, timers, Team_Done, Dispatch_Valid all 0; FSM = IDLE.
  - Serve is suppressed in the Recall cycle.
  - Dispatch_Zone/Priority/Team and Dispatch_Count hold.
- Boundary conditions:
  - All teams busy: stay in IDLE, Serve never asserted.
  - Queue empties (e.g. cancellation) between IDLE and ISSUE: abort, no Serve, no state change except FSM -> IDLE.
  - Enable dropping in ISSUE does not abort; the issue completes.
  - Multiple timers expiring in the same cycle: all corresponding Team_Done bits pulse together.
- Reset mid-mission: all state cleared immediately (asynchronous), no Team_Done pulses.

Test Plan:
- After reset, Shelter_Valid=1, Head_Zone=8'h2A, Head_Priority=2, Enable=1 -> Serve in cycle 1 only; then Dispatch_Valid=1, Dispatch_Team=0, Dispatch_Zone=8'h2A, Team_Busy=4'b0001; Team_Done[0] pulses 16 cycles after the busy edge.
- Continuous avail with varying heads, NUM_TEAMS=4 -> Serve at cycles 1, 4, 7, 10; teams 0-3 assigned in order; no fifth Serve until a Team_Done; first re-dispatch goes to the lowest freed index.
- Evac_Empty drops to 1 with Shelter_Valid=Food_Valid=0 in the ISSUE cycle -> Serve=0, Team_Busy unchanged, Dispatch_Count unchanged, FSM back to IDLE.
- Teams 0 and 2 busy, Recall pulsed -> next cycle Team_Busy=0, no Team_Done pulses, Dispatch_Count unchanged; with Recall asserted in the ISSUE cycle -> no Serve.
- Priority 0 and priority 3 dispatches at different times -> busy durations of exactly 8 and 20 cycles; if their expiries coincide -> both Team_Done bits pulse in the same cycle.
- Force Dispatch_Count to 16'hFFFE, perform 3 dispatches -> counter reads 16'hFFFF; assert Reset mid-mission -> all outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/dispatch_team_allocator.sv
// rtl/dispatch_team_allocator.sv - binds queue-head requests to free rescue teams
// and runs a priority-scaled mission timer per team.
module dispatch_team_allocator #(
  parameter int NUM_TEAMS    = 4,
  parameter int TEAM_W       = 2,
  parameter int MISSION_BASE = 8,
  parameter int MISSION_STEP = 4,
  parameter int TIMER_W      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 recall_i,
  input  logic                 evac_empty_i,
  input  logic                 shelter_valid_i,
  input  logic                 food_valid_i,
  input  logic [7:0]           head_zone_i,
  input  logic [1:0]           head_priority_i,
  output logic                 serve_o,
  output logic                 dispatch_valid_o,
  output logic [TEAM_W-1:0]    dispatch_team_o,
  output logic [7:0]           dispatch_zone_o,
  output logic [1:0]           dispatch_priority_o,
  output logic [NUM_TEAMS-1:0] team_busy_o,
  output logic [NUM_TEAMS-1:0] team_done_o,
  output logic [15:0]          dispatch_count_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

  state_t               state_q, state_d;
  logic [NUM_TEAMS-1:0] busy_q, busy_d;
  logic [NUM_TEAMS-1:0] done_q, done_d;
  logic [TIMER_W-1:0]   timer_q [NUM_TEAMS];
  logic [TIMER_W-1:0]   timer_d [NUM_TEAMS];
  logic                 valid_q, valid_d;
  logic [TEAM_W-1:0]    team_q, team_d;
  logic [7:0]           zone_q, zone_d;
  logic [1:0]           prio_q, prio_d;
  logic [15:0]          count_q, count_d;

  logic                 avail, any_free, serve;
  logic [NUM_TEAMS-1:0] free;
  logic [TEAM_W-1:0]    sel;
  logic [TIMER_W-1:0]   mission;

  assign avail    = ~evac_empty_i | shelter_valid_i | food_valid_i;
  assign free     = ~busy_q;
  assign any_free = |free;
  assign serve    = (state_q == ISSUE) & avail & any_free & ~recall_i;
  assign mission  = TIMER_W'(MISSION_BASE) + TIMER_W'(MISSION_STEP) * TIMER_W'(head_priority_i);

  // Scan downward so the lowest free index wins.
  always_comb begin
    sel = '0;
    for (int i = NUM_TEAMS - 1; i >= 0; i--) begin
      if (free[i]) sel = TEAM_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_i & avail & any_free & ~recall_i) state_d = ISSUE;
      ISSUE:   state_d = serve ? SETTLE : IDLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (recall_i) state_d = IDLE;
  end

  always_comb begin
    busy_d  = busy_q;
    done_d  = '0;
    valid_d = serve;
    team_d  = team_q;
    zone_d  = zone_q;
    prio_d  = prio_q;
    count_d = count_q;
    for (int i = 0; i < NUM_TEAMS; i++) begin
      timer_d[i] = timer_q[i];
      if (busy_q[i]) begin
        if (timer_q[i] == TIMER_W'(1)) begin
          timer_d[i] = '0;
          busy_d[i]  = 1'b0;
          done_d[i]  = 1'b1;
        end else begin
          timer_d[i] = timer_q[i] - TIMER_W'(1);
        end
      end
    end
    // A team freed at this edge is not in free yet, so sel never collides with expiry.
    if (serve) begin
      busy_d[sel]  = 1'b1;
      timer_d[sel] = mission;
      team_d       = sel;
      zone_d       = head_zone_i;
      prio_d       = head_priority_i;
      if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
    end
    if (recall_i) begin
      busy_d  = '0;
      done_d  = '0;
      valid_d = 1'b0;
      for (int i = 0; i < NUM_TEAMS; i++) timer_d[i] = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      busy_q  <= '0;
      done_q  <= '0;
      valid_q <= 1'b0;
      team_q  <= '0;
      zone_q  <= '0;
      prio_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < NUM_TEAMS; i++) timer_q[i] <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      team_q  <= team_d;
      zone_q  <= zone_d;
      prio_q  <= prio_d;
      count_q <= count_d;
      for (int i = 0; i < NUM_TEAMS; i++) timer_q[i] <= timer_d[i];
    end
  end

  assign serve_o             = serve;
  assign dispatch_valid_o    = valid_q;
  assign dispatch_team_o     = team_q;
  assign dispatch_zone_o     = zone_q;
  assign dispatch_priority_o = prio_q;
  assign team_busy_o         = busy_q;
  assign team_done_o         = done_q;
  assign dispatch_count_o    = count_q;

endmodule
